// File: rtl/reset_seq_pkg.sv
// Shared constants and types for the CPU reset sequencer: state encoding,
// default sequence lengths and the reset-kind type.
package reset_seq_pkg;

    localparam int CNT_W   = 8;
    localparam int STATE_W = 2;

    localparam int RST_LEN_DEF      = 16;
    localparam int SETTLE_LEN_DEF   = 4;
    localparam int HOLD_TIMEOUT_DEF = 255;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_HOLDW  = 2'd1;
    localparam logic [STATE_W-1:0] ST_ASSERT = 2'd2;
    localparam logic [STATE_W-1:0] ST_SETTLE = 2'd3;

    typedef enum logic {
        KIND_COLD = 1'b0,
        KIND_WARM = 1'b1
    } seq_kind_e;

    // A cold reset re-enables the boot ROM; a warm (BLK+SBR) reset keeps it out of the map.
    function automatic logic rom_disable_for(input seq_kind_e kind);
        return (kind == KIND_WARM);
    endfunction

endpackage

// File: rtl/ce_tick_counter.sv
// Counts cpu_ce ticks while enabled and flags the tick that reaches term_len.
// Shared by the ASSERT and SETTLE phases; cleared on every state entry.
module ce_tick_counter
    import reset_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             ce,
    input  logic [CNT_W-1:0] term_len,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && ce) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // done marks the edge that samples the term_len-th tick, not the one after it.
    assign done = enable && ce && (count_q == term_len - CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reset_seq_ctl.sv
// CPU reset sequencer: request a bus hold, wait for HLDA (or time out), pulse
// the CPU reset for RST_LEN ticks, then keep the bus held for SETTLE_LEN ticks.
module reset_seq_ctl
    import reset_seq_pkg::*;
#(
    parameter int RST_LEN      = RST_LEN_DEF,
    parameter int SETTLE_LEN   = SETTLE_LEN_DEF,
    parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_ce,
    input  logic req_cold,
    input  logic req_warm,
    input  logic req_hold,
    input  logic hold_ack,
    output logic o_hold,
    output logic o_cpu_reset,
    output logic o_disable_rom,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] RST_LEN_C      = CNT_W'(RST_LEN);
    localparam logic [CNT_W-1:0] SETTLE_LEN_C   = CNT_W'(SETTLE_LEN);
    localparam logic [CNT_W-1:0] HOLD_TIMEOUT_C = CNT_W'(HOLD_TIMEOUT);

    logic [STATE_W-1:0] state_q, state_d;
    seq_kind_e          kind_q, kind_d;
    logic               pend_cold_q, pend_cold_d;
    logic               pend_warm_q, pend_warm_d;
    logic               cold_prev_q, cold_prev_d;
    logic               warm_prev_q, warm_prev_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               o_hold_q, o_hold_d;
    logic               o_cpu_reset_q, o_cpu_reset_d;
    logic               o_disable_rom_q, o_disable_rom_d;
    logic               o_busy_q, o_busy_d;

    logic               cold_edge, warm_edge;
    logic               clr_cold, clr_warm;
    logic               state_entry;
    logic               tick_enable;
    logic [CNT_W-1:0]   tick_len;
    logic               tick_done;

    assign cold_edge   = req_cold && !cold_prev_q;
    assign warm_edge   = req_warm && !warm_prev_q;
    assign state_entry = (state_d != state_q);
    assign tick_enable = (state_q == ST_ASSERT) || (state_q == ST_SETTLE);
    assign tick_len    = (state_q == ST_ASSERT) ? RST_LEN_C : SETTLE_LEN_C;

    ce_tick_counter u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (state_entry),
        .enable   (tick_enable),
        .ce       (cpu_ce),
        .term_len (tick_len),
        .done     (tick_done)
    );

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        clr_cold = 1'b0;
        clr_warm = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Cold wins over warm and swallows a warm request raised alongside it.
                if (pend_cold_q) begin
                    state_d  = ST_HOLDW;
                    kind_d   = KIND_COLD;
                    clr_cold = 1'b1;
                    clr_warm = 1'b1;
                end else if (pend_warm_q) begin
                    state_d  = ST_HOLDW;
                    kind_d   = KIND_WARM;
                    clr_warm = 1'b1;
                end
            end
            ST_HOLDW: begin
                // A CPU that never grants HLDA is reset anyway once the wait expires.
                if (hold_ack || (hold_cnt_q == HOLD_TIMEOUT_C - CNT_W'(1))) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (tick_done) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tick_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh edge re-arms a flag even on the cycle its older request is accepted.
        pend_cold_d = (pend_cold_q && !clr_cold) || cold_edge;
        pend_warm_d = (pend_warm_q && !clr_warm) || warm_edge;
        cold_prev_d = req_cold;
        warm_prev_d = req_warm;

        hold_cnt_d = '0;
        if (!state_entry && (state_q == ST_HOLDW)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end

        o_disable_rom_d = o_disable_rom_q;
        if ((state_q == ST_HOLDW) && (state_d == ST_ASSERT)) begin
            o_disable_rom_d = rom_disable_for(kind_q);
        end

        // Outputs are decoded from the next state so they line up with state_q after the edge.
        o_hold_d      = (state_d == ST_IDLE) ? req_hold : 1'b1;
        o_cpu_reset_d = (state_d == ST_ASSERT);
        o_busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            kind_q          <= KIND_COLD;
            pend_cold_q     <= 1'b0;
            pend_warm_q     <= 1'b0;
            cold_prev_q     <= 1'b0;
            warm_prev_q     <= 1'b0;
            hold_cnt_q      <= '0;
            o_hold_q        <= 1'b0;
            o_cpu_reset_q   <= 1'b0;
            o_disable_rom_q <= 1'b0;
            o_busy_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            kind_q          <= kind_d;
            pend_cold_q     <= pend_cold_d;
            pend_warm_q     <= pend_warm_d;
            cold_prev_q     <= cold_prev_d;
            warm_prev_q     <= warm_prev_d;
            hold_cnt_q      <= hold_cnt_d;
            o_hold_q        <= o_hold_d;
            o_cpu_reset_q   <= o_cpu_reset_d;
            o_disable_rom_q <= o_disable_rom_d;
            o_busy_q        <= o_busy_d;
        end
    end

    assign o_hold        = o_hold_q;
    assign o_cpu_reset   = o_cpu_reset_q;
    assign o_disable_rom = o_disable_rom_q;
    assign o_busy        = o_busy_q;

endmodule
